// File: rtl/cmp_slice_cascade.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_slice_cascade
//  Purpose  : Serial cascade stage for a 2-bit magnitude comparator. Takes one
//             slice result (e/g/l) per handshake, most-significant slice
//             first, and resolves the equal/greater/less relation of two
//             NSLICES*2-bit words. The first non-equal slice decides.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_slice_cascade #(
    parameter int NSLICES = 4,   // slices per word, 1..255
    parameter int CW      = 8    // slice counter width, 2**CW > NSLICES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic          s_e,
    input  logic          s_g,
    input  logic          s_l,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic          err,
    output logic [CW-1:0] slice_cnt
);

    // Count value of the final slice and the saturation ceiling.
    localparam logic [CW-1:0] c_last = CW'(NSLICES - 1);
    localparam logic [CW-1:0] c_full = CW'(NSLICES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t r_state;

    // Pending result: once r_decided is set the pending flags are frozen so
    // less-significant slices cannot override the more-significant verdict.
    logic r_decided;
    logic r_pend_gt;
    logic r_pend_lt;

    logic w_onehot;
    logic w_dec_gt;
    logic w_dec_lt;
    logic w_nxt_gt;
    logic w_nxt_lt;
    logic w_accept;
    logic w_last;

    // Slice classification and the pending result including the current slice.
    // A malformed slice (zero or several flags) never decides: it counts as equal.
    always_comb begin
        w_onehot = (s_e & ~s_g & ~s_l) |
                   (~s_e & s_g & ~s_l) |
                   (~s_e & ~s_g & s_l);
        w_dec_gt = ~r_decided & w_onehot & s_g;
        w_dec_lt = ~r_decided & w_onehot & s_l;
        w_nxt_gt = r_pend_gt | w_dec_gt;
        w_nxt_lt = r_pend_lt | w_dec_lt;
        w_accept = s_valid & s_ready;
        w_last   = (slice_cnt == c_last);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_decided <= 1'b0;
            r_pend_gt <= 1'b0;
            r_pend_lt <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            err       <= 1'b0;
            slice_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Previous results stay visible until a new start.
                    done <= 1'b0;
                    if (start) begin
                        r_state   <= S_COLLECT;
                        s_ready   <= 1'b1;
                        busy      <= 1'b1;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        err       <= 1'b0;
                        slice_cnt <= '0;
                        r_decided <= 1'b0;
                        r_pend_gt <= 1'b0;
                        r_pend_lt <= 1'b0;
                    end
                end

                S_COLLECT: begin
                    // start is deliberately ignored here; s_valid low simply holds.
                    if (w_accept) begin
                        if (slice_cnt != c_full) begin
                            slice_cnt <= slice_cnt + CW'(1);
                        end
                        if (!w_onehot) begin
                            err <= 1'b1;
                        end
                        r_pend_gt <= w_nxt_gt;
                        r_pend_lt <= w_nxt_lt;
                        r_decided <= r_decided | w_dec_gt | w_dec_lt;
                        if (w_last) begin
                            // Final slice: publish the result and stop accepting
                            // so no extra slice is taken on the next edge.
                            r_state <= S_DONE;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            gt      <= w_nxt_gt;
                            lt      <= w_nxt_lt;
                            eq      <= ~(w_nxt_gt | w_nxt_lt);
                        end
                    end
                end

                S_DONE: begin
                    // Single-cycle result strobe, then back to IDLE.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_slice_cascade.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_slice_cascade
//  Purpose  : Directed self-checking bench for cmp_slice_cascade (NSLICES=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_slice_cascade;

    localparam int NSLICES = 4;
    localparam int CW      = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_e;
    logic          s_g;
    logic          s_l;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic          eq;
    logic          gt;
    logic          lt;
    logic          err;
    logic [CW-1:0] slice_cnt;

    int total;
    int bad;

    // Captured at the done strobe by run_cmp.
    logic [3:0]    r_res;     // {eq,gt,lt,err}
    logic [CW-1:0] r_cnt;
    int            r_rdy;
    int            r_acc;
    int            r_lat;

    // Slice codes {e,g,l}
    localparam logic [2:0] E  = 3'b100;
    localparam logic [2:0] G  = 3'b010;
    localparam logic [2:0] L  = 3'b001;
    localparam logic [2:0] EG = 3'b110;

    cmp_slice_cascade #(.NSLICES(NSLICES), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_e       (s_e),
        .s_g       (s_g),
        .s_l       (s_l),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .err       (err),
        .slice_cnt (slice_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full comparison. Inputs change only at falling edges; outputs are
    // observed there too. sl holds four slices, MSB slice in bits [11:9].
    task automatic run_cmp(input logic [11:0] sl, input bit gap, input bit hold);
        int  i;
        int  rdy;
        int  cyc;
        int  last;
        bit  seen;
        bit  ph;
        i = 0; rdy = 0; cyc = 0; last = -100; seen = 1'b0; ph = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        while (!seen && cyc < 40) begin
            if (done) begin
                seen  = 1'b1;
                r_res = {eq, gt, lt, err};
                r_cnt = slice_cnt;
                r_lat = cyc - last;
            end else begin
                if (s_ready) rdy++;
                if (s_ready && i < NSLICES && (!gap || !ph)) begin
                    s_valid = 1'b1;
                    {s_e, s_g, s_l} = sl[11 - 3*i -: 3];
                    i++;
                    last = cyc;
                end else begin
                    s_valid = 1'b0;
                    {s_e, s_g, s_l} = 3'b000;
                end
                ph = ~ph;
                cyc++;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        {s_e, s_g, s_l} = 3'b000;
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
        r_rdy = rdy;
        r_acc = i;
    endtask

    initial begin
        total = 0; bad = 0;
        start = 1'b0; s_valid = 1'b0; s_e = 1'b0; s_g = 1'b0; s_l = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_val("reset_state", {s_ready, busy, done, eq, gt, lt, err, slice_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 0xB4 vs 0xB1: e,e,g,l, valid held high
        run_cmp({E, E, G, L}, 1'b0, 1'b0);
        check_val("b4_res", r_res, 4'b0100);
        check_val("b4_cnt", r_cnt, 4);
        check_val("b4_ready_cycles", r_rdy, 4);
        check_val("b4_latency", r_lat, 1);
        check_val("b4_ready_at_done", s_ready, 1'b0);
        @(negedge clk);
        check_val("b4_done_once", done, 1'b0);

        // 0x5A vs 0x5A: e,e,e,e, valid every other cycle
        run_cmp({E, E, E, E}, 1'b1, 1'b0);
        check_val("5a_res", r_res, 4'b1000);
        check_val("5a_ready_cycles", r_rdy, 7);
        check_val("5a_accepts", r_acc, 4);
        @(negedge clk);
        check_val("5a_done_once", done, 1'b0);

        // 0x3F vs 0xC0: l,g,g,g
        run_cmp({L, G, G, G}, 1'b0, 1'b0);
        check_val("3f_res", r_res, 4'b0010);

        // Malformed second slice
        run_cmp({E, EG, E, E}, 1'b0, 1'b0);
        check_val("inv_res", r_res, 4'b1001);
        repeat (2) @(negedge clk);
        check_val("inv_held", {busy, eq, gt, lt, err}, 5'b01001);

        // Reset mid-run, also checks err clears on start
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("err_cleared", {busy, s_ready, err, eq}, 4'b1100);
        s_valid = 1'b1; {s_e, s_g, s_l} = E;
        @(negedge clk);
        s_valid = 1'b1; {s_e, s_g, s_l} = G;
        @(negedge clk);
        s_valid = 1'b0; {s_e, s_g, s_l} = 3'b000;
        check_val("mid_cnt", slice_cnt, 2);
        #2 rst_n = 1'b0;
        #1 check_val("mid_reset", {s_ready, busy, done, eq, gt, lt, err, slice_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        run_cmp({G, E, E, E}, 1'b0, 1'b0);
        check_val("post_rst_res", r_res, 4'b0100);
        check_val("post_rst_cnt", r_cnt, 4);

        // start held high across the whole run
        run_cmp({E, L, E, E}, 1'b0, 1'b1);
        check_val("hold_res", r_res, 4'b0010);
        check_val("hold_cnt", r_cnt, 4);
        @(negedge clk);
        check_val("hold_idle", {busy, s_ready, done, eq, gt, lt}, 6'b000001);
        @(negedge clk);
        check_val("hold_restart", {busy, s_ready, eq, gt, lt, err}, 6'b110000);
        check_val("hold_restart_cnt", slice_cnt, 0);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
